// File: rtl/ls_queue_pkg.sv
// ls_pkg: shared types for the load/store queue.
// Op-type constants, tag width, operand and entry records, address helper.
package ls_pkg;

    localparam int   W_TAG       = 6;
    localparam logic LS_OP_LOAD  = 1'b0;
    localparam logic LS_OP_STORE = 1'b1;

    typedef struct packed {
        logic [31:0]      val;
        logic [W_TAG-1:0] tag;
        logic             rdy;
    } operand_t;

    typedef struct packed {
        logic             valid;
        logic             opcode;
        logic [W_TAG-1:0] tag;
        logic [15:0]      imm;
        operand_t         rs;
        operand_t         rt;
    } entry_t;

    // base + sign-extended 16-bit offset, carry out dropped
    function automatic logic [31:0] eff_addr(
        input logic [31:0] base,
        input logic [15:0] imm
    );
        return base + {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/ls_queue_if.sv
// ls_queue_if: dispatch and issue bundle of the load/store queue.
// master = dispatch/consumer side, slave = the queue.
interface ls_queue_if #(
    parameter int W_TAG = 6
);

    logic             dispatch_valid;
    logic             dispatch_ready;
    logic             dispatch_opcode;
    logic [W_TAG-1:0] dispatch_tag;
    logic [15:0]      dispatch_imm;
    logic [31:0]      dispatch_rs_data;
    logic [W_TAG-1:0] dispatch_rs_tag;
    logic             dispatch_rs_valid;
    logic [31:0]      dispatch_rt_data;
    logic [W_TAG-1:0] dispatch_rt_tag;
    logic             dispatch_rt_valid;

    logic             lsq_valid;
    logic             lsq_opcode;
    logic [31:0]      lsq_address;
    logic [31:0]      lsq_data;
    logic [W_TAG-1:0] lsq_tag;

    modport master (
        output dispatch_valid, dispatch_opcode,
        output dispatch_tag, dispatch_imm,
        output dispatch_rs_data, dispatch_rs_tag,
        output dispatch_rs_valid,
        output dispatch_rt_data, dispatch_rt_tag,
        output dispatch_rt_valid,
        input  dispatch_ready,
        input  lsq_valid, lsq_opcode, lsq_address,
        input  lsq_data, lsq_tag
    );

    modport slave (
        input  dispatch_valid, dispatch_opcode,
        input  dispatch_tag, dispatch_imm,
        input  dispatch_rs_data, dispatch_rs_tag,
        input  dispatch_rs_valid,
        input  dispatch_rt_data, dispatch_rt_tag,
        input  dispatch_rt_valid,
        output dispatch_ready,
        output lsq_valid, lsq_opcode, lsq_address,
        output lsq_data, lsq_tag
    );

endinterface

// File: rtl/ls_queue_operand.sv
// ls_queue_operand: one operand slot of a queue entry.
// Ports: wr_* load on dispatch, snoop_en enables CDB capture, opnd = slot.
module ls_queue_operand
    import ls_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [31:0]      wr_val,
    input  logic [W_TAG-1:0] wr_tag,
    input  logic             wr_rdy,
    input  logic             snoop_en,
    input  logic             cdb_valid,
    input  logic [W_TAG-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output operand_t         opnd
);

    operand_t opnd_q;
    operand_t opnd_d;
    logic     hit_wr;
    logic     hit_snoop;

    // bypass: producer broadcasts in the same cycle the op is written
    assign hit_wr = cdb_valid & ~wr_rdy
                  & (cdb_tag == wr_tag);
    assign hit_snoop = cdb_valid & snoop_en & ~opnd_q.rdy
                     & (cdb_tag == opnd_q.tag);

    always_comb begin
        opnd_d = opnd_q;
        if (wr_en) begin
            opnd_d.val = wr_val;
            opnd_d.tag = wr_tag;
            opnd_d.rdy = wr_rdy;
            if (hit_wr) begin
                opnd_d.val = cdb_data;
                opnd_d.rdy = 1'b1;
            end
        end else if (hit_snoop) begin
            opnd_d.val = cdb_data;
            opnd_d.rdy = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) opnd_q <= '0;
        else       opnd_q <= opnd_d;
    end

    assign opnd = opnd_q;

endmodule

// File: rtl/ls_queue.sv
// ls_queue: in-order load/store queue issuing resolved ops to the dcache.
// Ports: clk/reset/flush, cdb_* snoop, issue_en grant, bus = dispatch+issue.
module ls_queue
    import ls_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W_TAG = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             cdb_valid,
    input  logic [W_TAG-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    input  logic             issue_en,
    ls_queue_if.slave        bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] opc_q, opc_d;
    logic [W_TAG-1:0] tag_q [DEPTH];
    logic [W_TAG-1:0] tag_d [DEPTH];
    logic [15:0]      imm_q [DEPTH];
    logic [15:0]      imm_d [DEPTH];
    operand_t         rs_q  [DEPTH];
    operand_t         rt_q  [DEPTH];

    logic             out_valid_q, out_valid_d;
    logic             out_opc_q, out_opc_d;
    logic [31:0]      out_addr_q, out_addr_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [W_TAG-1:0] out_tag_q, out_tag_d;

    entry_t head_e;
    logic   ready;
    logic   resolved;
    logic   enq;
    logic   deq;
    logic   rt_wr_rdy;

    assign ready = (count_q != CW'(DEPTH));

    always_comb begin
        head_e        = '0;
        head_e.valid  = valid_q[head_q];
        head_e.opcode = opc_q[head_q];
        head_e.tag    = tag_q[head_q];
        head_e.imm    = imm_q[head_q];
        head_e.rs     = rs_q[head_q];
        head_e.rt     = rt_q[head_q];
    end

    assign resolved = head_e.valid & head_e.rs.rdy
                    & head_e.rt.rdy;
    assign enq = bus.dispatch_valid & ready & ~flush;
    assign deq = resolved & issue_en & ~flush;

    // loads carry no store data, so their rt never blocks
    assign rt_wr_rdy = bus.dispatch_rt_valid
                     | (bus.dispatch_opcode == LS_OP_LOAD);

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic wr;
        assign wr = enq & (tail_q == PW'(i));

        ls_queue_operand u_rs (
            .clk       (clk),
            .reset     (reset),
            .wr_en     (wr),
            .wr_val    (bus.dispatch_rs_data),
            .wr_tag    (bus.dispatch_rs_tag),
            .wr_rdy    (bus.dispatch_rs_valid),
            .snoop_en  (valid_q[i]),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .opnd      (rs_q[i])
        );

        ls_queue_operand u_rt (
            .clk       (clk),
            .reset     (reset),
            .wr_en     (wr),
            .wr_val    (bus.dispatch_rt_data),
            .wr_tag    (bus.dispatch_rt_tag),
            .wr_rdy    (rt_wr_rdy),
            .snoop_en  (valid_q[i]),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .opnd      (rt_q[i])
        );
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        opc_d   = opc_q;
        tag_d   = tag_q;
        imm_d   = imm_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
        end else begin
            if (enq) begin
                valid_d[tail_q] = 1'b1;
                opc_d[tail_q]   = bus.dispatch_opcode;
                tag_d[tail_q]   = bus.dispatch_tag;
                imm_d[tail_q]   = bus.dispatch_imm;
                tail_d          = tail_q + 1'b1;
            end
            if (deq) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + 1'b1;
            end
            unique case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        out_valid_d = deq;
        out_opc_d   = out_opc_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        if (deq) begin
            out_opc_d  = head_e.opcode;
            out_addr_d = eff_addr(head_e.rs.val, head_e.imm);
            out_data_d = (head_e.opcode == LS_OP_STORE)
                       ? head_e.rt.val : 32'h0;
            out_tag_d  = head_e.tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            opc_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
                imm_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_opc_q   <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            opc_q       <= opc_d;
            tag_q       <= tag_d;
            imm_q       <= imm_d;
            out_valid_q <= out_valid_d;
            out_opc_q   <= out_opc_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign bus.dispatch_ready = ready;
    assign bus.lsq_valid      = out_valid_q;
    assign bus.lsq_opcode     = out_opc_q;
    assign bus.lsq_address    = out_addr_q;
    assign bus.lsq_data       = out_data_q;
    assign bus.lsq_tag        = out_tag_q;

endmodule

// File: tb/tb_ls_queue.sv
// tb_ls_queue: directed scenarios for ls_queue.
// One task per scenario, inline expected-value comparisons.
module tb_ls_queue;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       cdb_valid;
    logic [5:0] cdb_tag;
    logic [31:0] cdb_data;
    logic       issue_en;
    int         passed;
    int         total;

    ls_queue_if #(.W_TAG(6)) bus ();

    ls_queue #(.DEPTH(4), .W_TAG(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .issue_en  (issue_en),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(
        input logic        op,
        input logic [5:0]  tg,
        input logic [15:0] im,
        input logic [31:0] rsd,
        input logic [5:0]  rst,
        input logic        rsv,
        input logic [31:0] rtd,
        input logic [5:0]  rtt,
        input logic        rtv
    );
        bus.dispatch_valid    = 1'b1;
        bus.dispatch_opcode   = op;
        bus.dispatch_tag      = tg;
        bus.dispatch_imm      = im;
        bus.dispatch_rs_data  = rsd;
        bus.dispatch_rs_tag   = rst;
        bus.dispatch_rs_valid = rsv;
        bus.dispatch_rt_data  = rtd;
        bus.dispatch_rt_tag   = rtt;
        bus.dispatch_rt_valid = rtv;
    endtask

    task automatic idle;
        bus.dispatch_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (bus.lsq_valid !== 1'b0) $display("FAIL rst_valid: got %0b exp 0", bus.lsq_valid); else passed++;
        total++; if (bus.lsq_opcode !== 1'b0) $display("FAIL rst_opcode: got %0b exp 0", bus.lsq_opcode); else passed++;
        total++; if (bus.lsq_address !== 32'h0) $display("FAIL rst_addr: got %h exp 0", bus.lsq_address); else passed++;
        total++; if (bus.lsq_data !== 32'h0) $display("FAIL rst_data: got %h exp 0", bus.lsq_data); else passed++;
        total++; if (bus.lsq_tag !== 6'd0) $display("FAIL rst_tag: got %0d exp 0", bus.lsq_tag); else passed++;
        total++; if (bus.dispatch_ready !== 1'b1) $display("FAIL rst_ready: got %0b exp 1", bus.dispatch_ready); else passed++;
    endtask

    task automatic test_load;
        issue_en = 1'b1;
        drive(1'b0, 6'd5, 16'hFFFC, 32'h1000, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0);
        tick();
        idle();
        total++; if (bus.lsq_valid !== 1'b0) $display("FAIL load_early: got %0b exp 0", bus.lsq_valid); else passed++;
        tick();
        total++; if (bus.lsq_valid !== 1'b1) $display("FAIL load_valid: got %0b exp 1", bus.lsq_valid); else passed++;
        total++; if (bus.lsq_address !== 32'h00000FFC) $display("FAIL load_addr: got %h exp 00000ffc", bus.lsq_address); else passed++;
        total++; if (bus.lsq_opcode !== 1'b0) $display("FAIL load_opcode: got %0b exp 0", bus.lsq_opcode); else passed++;
        total++; if (bus.lsq_data !== 32'h0) $display("FAIL load_data: got %h exp 0", bus.lsq_data); else passed++;
        total++; if (bus.lsq_tag !== 6'd5) $display("FAIL load_tag: got %0d exp 5", bus.lsq_tag); else passed++;
        tick();
        total++; if (bus.lsq_valid !== 1'b0) $display("FAIL load_once: got %0b exp 0", bus.lsq_valid); else passed++;
    endtask

    task automatic test_store_wakeup;
        issue_en = 1'b1;
        drive(1'b1, 6'd9, 16'h0004, 32'h100, 6'd0, 1'b1, 32'h0, 6'd3, 1'b0);
        tick();
        idle();
        tick();
        tick();
        total++; if (bus.lsq_valid !== 1'b0) $display("FAIL st_blocked: got %0b exp 0", bus.lsq_valid); else passed++;
        cdb_valid = 1'b1;
        cdb_tag   = 6'd3;
        cdb_data  = 32'hDEADBEEF;
        tick();
        cdb_valid = 1'b0;
        total++; if (bus.lsq_valid !== 1'b0) $display("FAIL st_wake_early: got %0b exp 0", bus.lsq_valid); else passed++;
        tick();
        total++; if (bus.lsq_valid !== 1'b1) $display("FAIL st_valid: got %0b exp 1", bus.lsq_valid); else passed++;
        total++; if (bus.lsq_data !== 32'hDEADBEEF) $display("FAIL st_data: got %h exp deadbeef", bus.lsq_data); else passed++;
        total++; if (bus.lsq_opcode !== 1'b1) $display("FAIL st_opcode: got %0b exp 1", bus.lsq_opcode); else passed++;
        total++; if (bus.lsq_address !== 32'h104) $display("FAIL st_addr: got %h exp 00000104", bus.lsq_address); else passed++;
        total++; if (bus.lsq_tag !== 6'd9) $display("FAIL st_tag: got %0d exp 9", bus.lsq_tag); else passed++;
        tick();
        total++; if (bus.lsq_valid !== 1'b0) $display("FAIL st_once: got %0b exp 0", bus.lsq_valid); else passed++;
    endtask

    task automatic test_fill;
        logic [5:0]  exp_tag [4];
        logic [31:0] exp_adr [4];
        exp_tag = '{6'd10, 6'd11, 6'd12, 6'd13};
        exp_adr = '{32'h40, 32'h100, 32'h200, 32'h300};
        issue_en = 1'b1;
        drive(1'b0, 6'd10, 16'h0, 32'h0, 6'd10, 1'b0, 32'h0, 6'd0, 1'b0);
        tick();
        drive(1'b0, 6'd11, 16'h0, 32'h100, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0);
        tick();
        drive(1'b0, 6'd12, 16'h0, 32'h200, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0);
        tick();
        total++; if (bus.dispatch_ready !== 1'b1) $display("FAIL fill_ready3: got %0b exp 1", bus.dispatch_ready); else passed++;
        drive(1'b0, 6'd13, 16'h0, 32'h300, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0);
        tick();
        total++; if (bus.dispatch_ready !== 1'b0) $display("FAIL fill_full: got %0b exp 0", bus.dispatch_ready); else passed++;
        drive(1'b0, 6'd14, 16'h0, 32'h400, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0);
        tick();
        tick();
        idle();
        total++; if (bus.dispatch_ready !== 1'b0) $display("FAIL fill_still_full: got %0b exp 0", bus.dispatch_ready); else passed++;
        total++; if (bus.lsq_valid !== 1'b0) $display("FAIL fill_blocked: got %0b exp 0", bus.lsq_valid); else passed++;
        cdb_valid = 1'b1;
        cdb_tag   = 6'd10;
        cdb_data  = 32'h40;
        tick();
        cdb_valid = 1'b0;
        total++; if (bus.lsq_valid !== 1'b0) $display("FAIL fill_wake_early: got %0b exp 0", bus.lsq_valid); else passed++;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (bus.lsq_valid !== 1'b1) $display("FAIL drain%0d_valid: got %0b exp 1", k, bus.lsq_valid); else passed++;
            total++; if (bus.lsq_tag !== exp_tag[k]) $display("FAIL drain%0d_tag: got %0d exp %0d", k, bus.lsq_tag, exp_tag[k]); else passed++;
            total++; if (bus.lsq_address !== exp_adr[k]) $display("FAIL drain%0d_addr: got %h exp %h", k, bus.lsq_address, exp_adr[k]); else passed++;
            if (k == 0) begin
                total++; if (bus.dispatch_ready !== 1'b1) $display("FAIL drain_ready: got %0b exp 1", bus.dispatch_ready); else passed++;
            end
        end
        tick();
        total++; if (bus.lsq_valid !== 1'b0) $display("FAIL drain_no5th: got %0b exp 0", bus.lsq_valid); else passed++;
    endtask

    task automatic test_bypass;
        issue_en = 1'b1;
        drive(1'b0, 6'd20, 16'h0008, 32'h0, 6'd7, 1'b0, 32'h0, 6'd0, 1'b0);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd7;
        cdb_data  = 32'h20;
        tick();
        idle();
        cdb_valid = 1'b0;
        total++; if (bus.lsq_valid !== 1'b0) $display("FAIL byp_early: got %0b exp 0", bus.lsq_valid); else passed++;
        tick();
        total++; if (bus.lsq_valid !== 1'b1) $display("FAIL byp_valid: got %0b exp 1", bus.lsq_valid); else passed++;
        total++; if (bus.lsq_address !== 32'h28) $display("FAIL byp_addr: got %h exp 00000028", bus.lsq_address); else passed++;
        total++; if (bus.lsq_tag !== 6'd20) $display("FAIL byp_tag: got %0d exp 20", bus.lsq_tag); else passed++;
        tick();
    endtask

    task automatic test_wrap;
        issue_en = 1'b1;
        drive(1'b0, 6'd21, 16'h0020, 32'hFFFFFFF0, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0);
        tick();
        idle();
        tick();
        total++; if (bus.lsq_valid !== 1'b1) $display("FAIL wrap_valid: got %0b exp 1", bus.lsq_valid); else passed++;
        total++; if (bus.lsq_address !== 32'h10) $display("FAIL wrap_addr: got %h exp 00000010", bus.lsq_address); else passed++;
        tick();
    endtask

    task automatic test_flush;
        issue_en = 1'b0;
        drive(1'b0, 6'd30, 16'h0, 32'h300, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0);
        tick();
        drive(1'b0, 6'd31, 16'h0, 32'h310, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0);
        tick();
        drive(1'b0, 6'd32, 16'h0, 32'h320, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0);
        tick();
        idle();
        issue_en = 1'b1;
        tick();
        total++; if (bus.lsq_tag !== 6'd30 || bus.lsq_valid !== 1'b1) $display("FAIL fl_issue: got v%0b t%0d exp v1 t30", bus.lsq_valid, bus.lsq_tag); else passed++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (bus.lsq_valid !== 1'b0) $display("FAIL fl_valid: got %0b exp 0", bus.lsq_valid); else passed++;
        total++; if (bus.dispatch_ready !== 1'b1) $display("FAIL fl_ready: got %0b exp 1", bus.dispatch_ready); else passed++;
        tick();
        total++; if (bus.lsq_valid !== 1'b0) $display("FAIL fl_empty: got %0b exp 0", bus.lsq_valid); else passed++;
        drive(1'b0, 6'd33, 16'h0010, 32'h500, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0);
        tick();
        idle();
        tick();
        total++; if (bus.lsq_tag !== 6'd33 || bus.lsq_valid !== 1'b1) $display("FAIL fl_after: got v%0b t%0d exp v1 t33", bus.lsq_valid, bus.lsq_tag); else passed++;
        total++; if (bus.lsq_address !== 32'h510) $display("FAIL fl_after_addr: got %h exp 00000510", bus.lsq_address); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_drain;
        issue_en = 1'b0;
        drive(1'b1, 6'd40, 16'h0004, 32'h1000, 6'd0, 1'b1, 32'h55, 6'd0, 1'b1);
        tick();
        drive(1'b1, 6'd41, 16'h0, 32'h2000, 6'd0, 1'b1, 32'h66, 6'd0, 1'b1);
        tick();
        drive(1'b0, 6'd42, 16'h0, 32'h3000, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0);
        tick();
        idle();
        issue_en = 1'b1;
        tick();
        total++; if (bus.lsq_data !== 32'h55 || bus.lsq_tag !== 6'd40) $display("FAIL md_issue: got d%h t%0d exp d55 t40", bus.lsq_data, bus.lsq_tag); else passed++;
        total++; if (bus.lsq_address !== 32'h1004) $display("FAIL md_addr: got %h exp 00001004", bus.lsq_address); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (bus.lsq_valid !== 1'b0) $display("FAIL md_valid: got %0b exp 0", bus.lsq_valid); else passed++;
        total++; if (bus.lsq_opcode !== 1'b0) $display("FAIL md_opcode: got %0b exp 0", bus.lsq_opcode); else passed++;
        total++; if (bus.lsq_address !== 32'h0) $display("FAIL md_addr0: got %h exp 0", bus.lsq_address); else passed++;
        total++; if (bus.lsq_data !== 32'h0) $display("FAIL md_data: got %h exp 0", bus.lsq_data); else passed++;
        total++; if (bus.lsq_tag !== 6'd0) $display("FAIL md_tag: got %0d exp 0", bus.lsq_tag); else passed++;
        total++; if (bus.dispatch_ready !== 1'b1) $display("FAIL md_ready: got %0b exp 1", bus.dispatch_ready); else passed++;
        tick();
        total++; if (bus.lsq_valid !== 1'b0) $display("FAIL md_empty: got %0b exp 0", bus.lsq_valid); else passed++;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        cdb_valid = 1'b0;
        cdb_tag   = 6'd0;
        cdb_data  = 32'h0;
        issue_en  = 1'b0;
        drive(1'b0, 6'd0, 16'h0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0);
        idle();
        test_reset();
        test_load();
        test_store_wakeup();
        test_fill();
        test_bypass();
        test_wrap();
        test_flush();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
